// File: rtl/alu_cmd_sequencer_if.sv
// Host command/response channel plus the ALU operand/result bus of the sequencer.
// The slave modport is the sequencer; the master side is the requester together with the ALU.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_fxn;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_acc;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_fxn;
  logic [WIDTH-1:0] alu_x;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_x;
  logic             rsp_zero;
  logic             rsp_neg;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_fxn, cmd_a, cmd_b, cmd_acc, rsp_ready, alu_x,
    input  cmd_ready, alu_a, alu_b, alu_fxn, rsp_valid, rsp_x, rsp_zero, rsp_neg, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_fxn, cmd_a, cmd_b, cmd_acc, rsp_ready, alu_x,
    output cmd_ready, alu_a, alu_b, alu_fxn, rsp_valid, rsp_x, rsp_zero, rsp_neg, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues one host command at a time to an external ALU, waits ALU_LAT cycles,
// and returns the captured result with flags; optional accumulator replaces operand A.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 6,
  parameter int ALU_LAT = 1
) (
  input logic                clk,
  input logic                rst_n,
  alu_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(ALU_LAT - 1);

  state_t           state;
  state_t           state_next;
  logic [3:0]       wait_cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;
  logic [2:0]       pend_fxn;

  logic accept;
  logic illegal;
  logic capture;

  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign illegal = (bus.cmd_fxn == 3'b100);
  assign capture = (state == WAIT) && (wait_cnt == LAST_WAIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = illegal ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (capture) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch-free and low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
    end else begin
      state         <= state_next;
      bus.cmd_ready <= (state_next == IDLE);
      bus.rsp_valid <= (state_next == RESP);
    end
  end

  // Command fields are latched on accept so the host may change cmd_* while the ALU works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a       <= '0;
      pend_b       <= '0;
      pend_fxn     <= '0;
      acc          <= '0;
      wait_cnt     <= '0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_fxn  <= '0;
      bus.rsp_x    <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_neg  <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else begin
      if (accept && !illegal) begin
        pend_a   <= bus.cmd_acc ? acc : bus.cmd_a;
        pend_b   <= bus.cmd_b;
        pend_fxn <= bus.cmd_fxn;
      end
      if (accept && illegal) begin
        bus.rsp_x    <= '0;
        bus.rsp_zero <= 1'b1;
        bus.rsp_neg  <= 1'b0;
        bus.rsp_err  <= 1'b1;
      end
      if (state == ISSUE) begin
        bus.alu_a   <= pend_a;
        bus.alu_b   <= pend_b;
        bus.alu_fxn <= pend_fxn;
        wait_cnt    <= '0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (capture) begin
        bus.rsp_x    <= bus.alu_x;
        acc          <= bus.alu_x;
        bus.rsp_zero <= (bus.alu_x == '0);
        bus.rsp_neg  <= bus.alu_x[WIDTH-1];
        bus.rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (ALU_LAT 1 and 3) share the stimulus,
// a stub ALU answers each, and a transaction-level model predicts every response.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_fxn = 3'd0;
  logic [5:0] cmd_a = 6'd0;
  logic [5:0] cmd_b = 6'd0;
  logic       cmd_acc = 1'b0;
  logic       rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [5:0] acc_m [2];
  logic [5:0] la [2];
  logic [5:0] lb [2];
  logic [2:0] lf [2];
  logic [5:0] got_x;
  logic [5:0] got_alu_a;

  alu_cmd_sequencer_if #(.WIDTH(6)) bus1 ();
  alu_cmd_sequencer_if #(.WIDTH(6)) bus3 ();

  alu_cmd_sequencer #(.WIDTH(6), .ALU_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  alu_cmd_sequencer #(.WIDTH(6), .ALU_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  function automatic logic [5:0] alu_f(input logic [2:0] f, input logic [5:0] a, input logic [5:0] b);
    case (f)
      3'b000:  return a;
      3'b001:  return b;
      3'b010:  return 6'd0 - a;
      3'b011:  return 6'd0 - b;
      3'b101:  return a ^ b;
      3'b110:  return a + b;
      3'b111:  return a - b;
      default: return 6'd0;
    endcase
  endfunction

  assign bus1.cmd_valid = cmd_valid & ~sel;
  assign bus3.cmd_valid = cmd_valid & sel;
  assign bus1.rsp_ready = rsp_ready & ~sel;
  assign bus3.rsp_ready = rsp_ready & sel;
  assign bus1.cmd_fxn = cmd_fxn;
  assign bus3.cmd_fxn = cmd_fxn;
  assign bus1.cmd_a = cmd_a;
  assign bus3.cmd_a = cmd_a;
  assign bus1.cmd_b = cmd_b;
  assign bus3.cmd_b = cmd_b;
  assign bus1.cmd_acc = cmd_acc;
  assign bus3.cmd_acc = cmd_acc;
  assign bus1.alu_x = alu_f(bus1.alu_fxn, bus1.alu_a, bus1.alu_b);
  assign bus3.alu_x = alu_f(bus3.alu_fxn, bus3.alu_a, bus3.alu_b);

  logic       o_cmd_ready, o_rsp_valid, o_rsp_zero, o_rsp_neg, o_rsp_err;
  logic [5:0] o_alu_a, o_alu_b, o_rsp_x;
  logic [2:0] o_alu_fxn;
  assign o_cmd_ready = sel ? bus3.cmd_ready : bus1.cmd_ready;
  assign o_rsp_valid = sel ? bus3.rsp_valid : bus1.rsp_valid;
  assign o_rsp_zero  = sel ? bus3.rsp_zero  : bus1.rsp_zero;
  assign o_rsp_neg   = sel ? bus3.rsp_neg   : bus1.rsp_neg;
  assign o_rsp_err   = sel ? bus3.rsp_err   : bus1.rsp_err;
  assign o_alu_a     = sel ? bus3.alu_a     : bus1.alu_a;
  assign o_alu_b     = sel ? bus3.alu_b     : bus1.alu_b;
  assign o_alu_fxn   = sel ? bus3.alu_fxn   : bus1.alu_fxn;
  assign o_rsp_x     = sel ? bus3.rsp_x     : bus1.rsp_x;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [5:0] a, input logic [5:0] b, input logic ua);
    cmd_fxn   = f;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = ua;
    cmd_valid = 1'b1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 2; i++) begin
      acc_m[i] = 6'd0;
      la[i]    = 6'd0;
      lb[i]    = 6'd0;
      lf[i]    = 3'd0;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, {31'd0, o_cmd_ready}, 32'd0);
    checkOutput({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
    checkOutput({tag, "_alu_a"}, {26'd0, o_alu_a}, 32'd0);
    checkOutput({tag, "_alu_fxn"}, {29'd0, o_alu_fxn}, 32'd0);
    checkOutput({tag, "_rsp_x"}, {26'd0, o_rsp_x}, 32'd0);
    checkOutput({tag, "_flags"}, {29'd0, o_rsp_zero, o_rsp_neg, o_rsp_err}, 32'd0);
  endtask

  // One command through the selected instance, called and returning at a falling edge.
  task automatic runTxn(input logic s, input logic [2:0] f, input logic [5:0] a, input logic [5:0] b,
                        input logic ua, input int hold);
    logic [5:0] opa, ex;
    logic       ez, en, ee, got;
    int         n, lat;
    sel = s;
    opa = ua ? acc_m[s] : a;
    if (f == 3'b100) begin
      ex = 6'd0; ez = 1'b1; en = 1'b0; ee = 1'b1; lat = 1;
    end else begin
      ex = alu_f(f, opa, b); ez = (ex == 6'd0); en = ex[5]; ee = 1'b0; lat = s ? 5 : 3;
    end
    checkOutput("cmd_ready_idle", {31'd0, o_cmd_ready}, 32'd1);
    applyStimulus(f, a, b, ua);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a     = 6'($urandom);
    cmd_b     = 6'($urandom);
    cmd_acc   = 1'($urandom);
    if (hold == 0) rsp_ready = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2 && f != 3'b100) begin
        got_alu_a = o_alu_a;
        checkOutput("alu_a", {26'd0, o_alu_a}, {26'd0, opa});
        checkOutput("alu_b", {26'd0, o_alu_b}, {26'd0, b});
        checkOutput("alu_fxn", {29'd0, o_alu_fxn}, {29'd0, f});
      end
      if (n == 1 && f == 3'b100) begin
        checkOutput("alu_a_kept", {26'd0, o_alu_a}, {26'd0, la[s]});
        checkOutput("alu_b_kept", {26'd0, o_alu_b}, {26'd0, lb[s]});
        checkOutput("alu_fxn_kept", {29'd0, o_alu_fxn}, {29'd0, lf[s]});
      end
      if (o_rsp_valid === 1'b1) got = 1'b1;
    end
    checkOutput("rsp_latency", n, lat);
    got_x = o_rsp_x;
    if (got) begin
      checkOutput("rsp_x", {26'd0, o_rsp_x}, {26'd0, ex});
      checkOutput("rsp_flags", {29'd0, o_rsp_zero, o_rsp_neg, o_rsp_err}, {29'd0, ez, en, ee});
      for (int i = 0; i < hold; i++) begin
        applyStimulus(3'b110, 6'($urandom), 6'($urandom), 1'b0);
        @(negedge clk);
        checkOutput("hold_valid", {31'd0, o_rsp_valid}, 32'd1);
        checkOutput("hold_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
        checkOutput("hold_rsp_x", {26'd0, o_rsp_x}, {26'd0, ex});
        checkOutput("hold_flags", {29'd0, o_rsp_zero, o_rsp_neg, o_rsp_err}, {29'd0, ez, en, ee});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("consumed_valid", {31'd0, o_rsp_valid}, 32'd0);
      checkOutput("consumed_ready", {31'd0, o_cmd_ready}, 32'd1);
    end
    rsp_ready = 1'b0;
    if (f != 3'b100) begin
      acc_m[s] = ex;
      la[s]    = opa;
      lb[s]    = b;
      lf[s]    = f;
    end
  endtask

  initial begin
    clearModel();
    got_x = 6'd0;
    got_alu_a = 6'd0;
    #2;
    sel = 1'b0;
    checkIdleOutputs("reset1");
    sel = 1'b1;
    checkIdleOutputs("reset3");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready3", {31'd0, o_cmd_ready}, 32'd1);
    sel = 1'b0;
    checkOutput("post_reset_ready1", {31'd0, o_cmd_ready}, 32'd1);

    runTxn(1'b0, 3'b110, 6'd5, 6'd3, 1'b0, 0);
    checkOutput("add_5_3", {26'd0, got_x}, 32'd8);
    runTxn(1'b0, 3'b111, 6'd3, 6'd5, 1'b0, 0);
    checkOutput("sub_3_5", {26'd0, got_x}, 32'h3E);
    runTxn(1'b0, 3'b110, 6'd9, 6'd2, 1'b1, 0);
    checkOutput("acc_alu_a", {26'd0, got_alu_a}, 32'h3E);
    checkOutput("acc_add", {26'd0, got_x}, 32'd0);
    runTxn(1'b0, 3'b100, 6'd17, 6'd40, 1'b0, 0);
    runTxn(1'b0, 3'b110, 6'd11, 6'd1, 1'b1, 5);
    checkOutput("acc_after_illegal", {26'd0, got_x}, 32'd1);
    runTxn(1'b0, 3'b110, 6'h3F, 6'd1, 1'b0, 0);
    checkOutput("wrap1", {26'd0, got_x}, 32'd0);
    runTxn(1'b1, 3'b110, 6'h3F, 6'd1, 1'b0, 2);
    checkOutput("wrap3", {26'd0, got_x}, 32'd0);
    runTxn(1'b1, 3'b010, 6'd1, 6'd0, 1'b0, 0);

    sel = 1'b1;
    applyStimulus(3'b110, 6'd4, 6'd4, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_abort_alu_a", {26'd0, o_alu_a}, 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("abort");
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    runTxn(1'b1, 3'b110, 6'd9, 6'd7, 1'b1, 0);
    checkOutput("acc_cleared_alu_a", {26'd0, got_alu_a}, 32'd0);
    checkOutput("acc_cleared_x", {26'd0, got_x}, 32'd7);

    for (int i = 0; i < 24; i++) begin
      runTxn(1'($urandom), 3'($urandom_range(0, 7)), 6'($urandom), 6'($urandom),
             1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
